// File: rtl/ysyx_25010008_clint_timer.sv
// CLINT slave (mtime/mtimecmp/msip) with valid/ready read and write channels; read and write responses arrive 2 cycles after the address/data handshake and are held until accepted.
// Writes take effect only when CLINT_WRITE_EN is defined; otherwise every write is answered with bresp=1.
module ysyx_25010008_clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic        rresp,
  output logic        rvalid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic        bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        mtip,
  output logic        msip_o
);
`ifdef CLINT_WRITE_EN
  localparam logic WR_EN = 1'b1;
`else
  localparam logic WR_EN = 1'b0;
`endif

  localparam logic [31:0] OFF_MSIP   = 32'h0000_0000;
  localparam logic [31:0] OFF_CMP_LO = 32'h0000_4000;
  localparam logic [31:0] OFF_CMP_HI = 32'h0000_4004;
  localparam logic [31:0] OFF_MT_LO  = 32'h0000_BFF8;
  localparam logic [31:0] OFF_MT_HI  = 32'h0000_BFFC;
  localparam logic [31:0] PRE_MAX    = 32'(TICK_DIV - 1);

  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_APPLY, W_RESP} w_state_e;

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic [31:0] raddr_q, raddr_d, rdata_q, rdata_d;
  logic        rresp_q, rresp_d;
  logic [31:0] waddr_q, waddr_d, wdat_q, wdat_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_got_q, aw_got_d, w_got_q, w_got_d, bresp_q, bresp_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [31:0] pre_q, pre_d;
  logic        msip_q, msip_d, mtip_q, mtip_d;
  logic [31:0] roff, woff;
  logic        aw_hs, w_hs;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = strb[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction

  assign roff    = raddr_q - BASE_ADDR;
  assign woff    = waddr_q - BASE_ADDR;
  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = (w_state_q == W_IDLE) && !aw_got_q;
  assign wready  = (w_state_q == W_IDLE) && !w_got_q;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;
  assign mtip    = mtip_q;
  assign msip_o  = msip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      w_state_q  <= W_IDLE;
      raddr_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= 1'b0;
      waddr_q    <= '0;
      wdat_q     <= '0;
      wstrb_q    <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      bresp_q    <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      pre_q      <= '0;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      w_state_q  <= w_state_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      waddr_q    <= waddr_d;
      wdat_q     <= wdat_d;
      wstrb_q    <= wstrb_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      bresp_q    <= bresp_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      pre_q      <= pre_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
    end
  end

  always_comb begin : next_state
    r_state_d = r_state_q;
    w_state_d = w_state_q;
    case (r_state_q)
      R_IDLE:  if (arvalid) r_state_d = R_READ;
      R_READ:  r_state_d = R_RESP;
      R_RESP:  if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    case (w_state_q)
      W_IDLE:  if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) w_state_d = W_APPLY;
      W_APPLY: w_state_d = W_RESP;
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin : datapath
    raddr_d    = raddr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    waddr_d    = waddr_q;
    wdat_d     = wdat_q;
    wstrb_d    = wstrb_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    bresp_d    = bresp_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    mtime_d    = mtime_q;
    pre_d      = pre_q + 32'd1;
    if (pre_q == PRE_MAX) begin
      pre_d   = '0;
      mtime_d = mtime_q + 64'd1;
    end

    if (r_state_q == R_IDLE && arvalid) raddr_d = araddr;
    // Reads sample the registers before any same-cycle write is applied.
    if (r_state_q == R_READ) begin
      rresp_d = 1'b0;
      rdata_d = '0;
      case (roff)
        OFF_MSIP:   rdata_d = {31'b0, msip_q};
        OFF_CMP_LO: rdata_d = mtimecmp_q[31:0];
        OFF_CMP_HI: rdata_d = mtimecmp_q[63:32];
        OFF_MT_LO:  rdata_d = mtime_q[31:0];
        OFF_MT_HI:  rdata_d = mtime_q[63:32];
        default:    rresp_d = 1'b1;
      endcase
    end

    if (w_state_q == W_IDLE) begin
      if (aw_hs) begin
        waddr_d  = awaddr;
        aw_got_d = 1'b1;
      end
      if (w_hs) begin
        wdat_d  = wdata;
        wstrb_d = wstrb;
        w_got_d = 1'b1;
      end
    end

    if (w_state_q == W_APPLY) begin
      aw_got_d = 1'b0;
      w_got_d  = 1'b0;
      bresp_d  = !WR_EN;
      case (woff)
        OFF_MSIP:   if (WR_EN && wstrb_q[0]) msip_d = wdat_q[0];
        OFF_CMP_LO: if (WR_EN) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wdat_q, wstrb_q);
        OFF_CMP_HI: if (WR_EN) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdat_q, wstrb_q);
        OFF_MT_LO: if (WR_EN) begin
          mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wdat_q, wstrb_q)};
          pre_d   = '0;
        end
        OFF_MT_HI: if (WR_EN) begin
          mtime_d = {merge(mtime_q[63:32], wdat_q, wstrb_q), mtime_q[31:0]};
          pre_d   = '0;
        end
        default:    bresp_d = 1'b1;
      endcase
    end

    mtip_d = (mtime_d >= mtimecmp_d);
  end
endmodule
